regfile_arbiter: RTL and testbench

- Sequences the 8 x 16-bit register file and shares its single read port and single write port between two requesters.
- Supported operations: read, write and register-to-register copy.
- Uses a round-robin grant and a per-requester req/ack handshake.
- Sits between the datapath control logic and the regfile instance; it is the only block that drives the regfile ports.

---
 rtl/regfile_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_regfile_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares the single read and single write port of an
// 8 x 16-bit register file between two requesters. It supports read,
// write and register-to-register copy, uses a round-robin grant, and gives
// each requester a req/ack handshake.
//
// Optional build macro RF_ARB_R0_PROTECT_EN: writes and copies that target
// R0 are suppressed. The FSM still completes and acks the access, and
// err0/err1 pulse together with the ack.
module regfile_arbiter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [1:0]        op0,
    input  logic [1:0]        op1,
    input  logic [ADDR_W-1:0] src0,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] dst0,
    input  logic [ADDR_W-1:0] dst1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
`ifdef RF_ARB_R0_PROTECT_EN
    output logic              err0,
    output logic              err1,
`endif
    output logic [DATA_W-1:0] rf_data_in,
    output logic [ADDR_W-1:0] rf_writenum,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_readnum,
    input  logic [DATA_W-1:0] rf_data_out
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_EXEC    = 2'd1;
    localparam logic [1:0] S_COPY_WR = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic              last_grant;
    logic              gnt;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] hold_q;

    logic              grant_valid_c;
    logic              grant_sel_c;
    logic              is_read_c;
    logic              is_write_c;
    logic              is_copy_c;
    logic              suppress_c;
    logic              done_next_c;

    // Round-robin pick: a lone requester wins; on a tie the one not granted last wins
    always_comb begin
        grant_valid_c = req0 | req1;
        grant_sel_c   = 1'b0;
        if (req0 && req1) begin
            grant_sel_c = ~last_grant;
        end else if (req1) begin
            grant_sel_c = 1'b1;
        end
    end

    // Decode the latched operation
    always_comb begin
        is_read_c  = (op_q == OP_READ);
        is_write_c = (op_q == OP_WRITE);
        is_copy_c  = (op_q == OP_COPY);
    end

    // Writes that must not reach the regfile (R0 protection when built in)
    always_comb begin
        suppress_c = 1'b0;
`ifdef RF_ARB_R0_PROTECT_EN
        if ((is_write_c || is_copy_c) && (dst_q == ADDR_W'(0))) begin
            suppress_c = 1'b1;
        end
`endif
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (grant_valid_c) begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_copy_c) begin
                    state_next = S_COPY_WR;
                end else begin
                    state_next = S_DONE;
                end
            end
            S_COPY_WR: state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    assign done_next_c = (state_next == S_DONE);

    // Regfile port drive: indices come straight from the latched operands
    always_comb begin
        rf_readnum  = src_q;
        rf_writenum = dst_q;
        rf_data_in  = wdata_q;
        rf_write    = 1'b0;
        if (state == S_COPY_WR) begin
            rf_data_in = hold_q;
            rf_write   = ~suppress_c;
        end else if ((state == S_EXEC) && is_write_c) begin
            rf_write   = ~suppress_c;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant bookkeeping and operand latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            op_q       <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            wdata_q    <= '0;
        end else if ((state == S_IDLE) && grant_valid_c) begin
            last_grant <= grant_sel_c;
            gnt        <= grant_sel_c;
            op_q       <= grant_sel_c ? op1    : op0;
            src_q      <= grant_sel_c ? src1   : src0;
            dst_q      <= grant_sel_c ? dst1   : dst0;
            wdata_q    <= grant_sel_c ? wdata1 : wdata0;
        end
    end

    // Copy source value, held for the write in COPY_WR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else if ((state == S_EXEC) && is_copy_c) begin
            hold_q <= rf_data_out;
        end
    end

    // Read result capture into the granted requester's rdata
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else if ((state == S_EXEC) && is_read_c) begin
            if (gnt) begin
                rdata1 <= rf_data_out;
            end else begin
                rdata0 <= rf_data_out;
            end
        end
    end

    // Ack and busy flags, registered so they line up with the DONE/non-IDLE state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            busy <= 1'b0;
        end else begin
            ack0 <= done_next_c & ~gnt;
            ack1 <= done_next_c &  gnt;
            busy <= (state_next != S_IDLE);
        end
    end

`ifdef RF_ARB_R0_PROTECT_EN
    // Error pulse alongside the ack of a suppressed R0 access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err0 <= 1'b0;
            err1 <= 1'b0;
        end else begin
            err0 <= done_next_c & ~gnt & suppress_c;
            err1 <= done_next_c &  gnt & suppress_c;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: a behavioural regfile plus a
// transaction-level reference model of the register contents and read results.
module tb_regfile_arbiter;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;
`ifdef RF_ARB_R0_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1;
    logic [1:0]    op0, op1;
    logic [AW-1:0] src0, src1, dst0, dst1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, busy;
    logic [DW-1:0] rdata0, rdata1;
    logic [DW-1:0] rf_data_in, rf_data_out;
    logic [AW-1:0] rf_writenum, rf_readnum;
    logic          rf_write;
`ifdef RF_ARB_R0_PROTECT_EN
    logic          err0, err1;
`endif

    logic          rf_clear;
    logic [DW-1:0] rf_mem [8];

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_rf [8];
    logic [DW-1:0] model_rd [2];

    always #5 clk = ~clk;

    regfile_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .src0(src0), .src1(src1), .dst0(dst0), .dst1(dst1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .busy(busy),
`ifdef RF_ARB_R0_PROTECT_EN
        .err0(err0), .err1(err1),
`endif
        .rf_data_in(rf_data_in), .rf_writenum(rf_writenum), .rf_write(rf_write),
        .rf_readnum(rf_readnum), .rf_data_out(rf_data_out)
    );

    // Behavioural 8 x 16 regfile the DUT sequences
    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= '0;
        end else if (rf_write) begin
            rf_mem[rf_writenum] <= rf_data_in;
        end
    end
    assign rf_data_out = rf_mem[rf_readnum];

    // Reference model: effect of one completed transaction
    task automatic model_op(input int who, input logic [1:0] op, input logic [AW-1:0] src,
                            input logic [AW-1:0] dst, input logic [DW-1:0] wd,
                            output int e_lat, output int e_wcnt, output int e_wcyc,
                            output logic [DW-1:0] e_wdat, output logic e_err);
        e_lat = 2; e_wcnt = 0; e_wcyc = 0; e_wdat = '0; e_err = 1'b0;
        case (op)
            2'b00: model_rd[who] = model_rf[src];
            2'b01: begin
                if (PROT && dst == 0) e_err = 1'b1;
                else begin
                    model_rf[dst] = wd; e_wcnt = 1; e_wcyc = 1; e_wdat = wd;
                end
            end
            2'b10: begin
                e_lat = 3;
                if (PROT && dst == 0) e_err = 1'b1;
                else begin
                    e_wdat = model_rf[src]; model_rf[dst] = model_rf[src];
                    e_wcnt = 1; e_wcyc = 2;
                end
            end
            default: ;
        endcase
    endtask

    task automatic set_req(input int who, input logic v, input logic [1:0] op,
                           input logic [AW-1:0] src, input logic [AW-1:0] dst,
                           input logic [DW-1:0] wd);
        if (who == 0) begin
            req0 = v; op0 = op; src0 = src; dst0 = dst; wdata0 = wd;
        end else begin
            req1 = v; op1 = op; src1 = src; dst1 = dst; wdata1 = wd;
        end
    endtask

    // Run one transaction from an idle DUT; called at posedge+1, returns at posedge+1 in IDLE
    task automatic do_op(input int who, input logic [1:0] op, input logic [AW-1:0] src,
                         input logic [AW-1:0] dst, input logic [DW-1:0] wd,
                         output int lat, output logic [DW-1:0] rd, output int wcnt,
                         output int wcyc, output logic [AW-1:0] wnum, output logic [DW-1:0] wdat,
                         output logic err_seen, output logic other_ack, output logic busy_exec);
        lat = -1; rd = '0; wcnt = 0; wcyc = 0; wnum = '0; wdat = '0;
        err_seen = 1'b0; other_ack = 1'b0; busy_exec = 1'b0;
        set_req(who, 1'b1, op, src, dst, wd);
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                busy_exec = busy;
                // operands after the grant must be ignored
                set_req(who, 1'b1, 2'($urandom_range(0, 3)), AW'($urandom_range(0, 7)),
                        AW'($urandom_range(0, 7)), DW'($urandom));
            end
            if (rf_write) begin
                wcnt++; wcyc = n; wnum = rf_writenum; wdat = rf_data_in;
            end
            if ((who == 0) ? ack1 : ack0) other_ack = 1'b1;
            if ((who == 0) ? ack0 : ack1) begin
                lat = n;
                rd  = (who == 0) ? rdata0 : rdata1;
`ifdef RF_ARB_R0_PROTECT_EN
                err_seen = (who == 0) ? err0 : err1;
`endif
                break;
            end
        end
        set_req(who, 1'b0, 2'b00, '0, '0, '0);
        @(posedge clk); #1;
        if (lat < 0) begin
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int lat;
        logic [1:0] first;
        rst_n = 1'b0; rf_clear = 1'b1;
        set_req(0, 1'b1, 2'b00, 3'd3, 3'd0, 16'h0);
        set_req(1, 1'b1, 2'b00, 3'd4, 3'd0, 16'h0);
        for (int i = 0; i < 8; i++) model_rf[i] = '0;
        model_rd[0] = '0; model_rd[1] = '0;
        repeat (2) @(posedge clk);
        #1 rf_clear = 1'b0;
        checks++;
        if ({ack0, ack1, busy, rf_write} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl got ack0/ack1/busy/rf_write=%b want 0000", {ack0, ack1, busy, rf_write});
        end
        checks++;
        if (rdata0 !== 16'h0 || rdata1 !== 16'h0) begin
            errors++; $display("FAIL reset_rdata got %h/%h want 0000/0000", rdata0, rdata1);
        end
        rst_n = 1'b1;
        lat = -1; first = 2'b00;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            if (ack0 || ack1) begin lat = n; first = {ack1, ack0}; break; end
        end
        set_req(0, 1'b0, 2'b00, '0, '0, '0);
        set_req(1, 1'b0, 2'b00, '0, '0, '0);
        checks++;
        if (first !== 2'b01) begin
            errors++; $display("FAIL reset_first_grant got {ack1,ack0}=%b want 01", first);
        end
        checks++;
        if (lat != 2) begin
            errors++; $display("FAIL reset_first_latency got %0d want 2", lat);
        end
        model_rd[0] = model_rf[3];
        checks++;
        if (rdata0 !== model_rd[0]) begin
            errors++; $display("FAIL reset_first_rdata got %h want %h", rdata0, model_rd[0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int lat, wcnt, wcyc, e_lat, e_wcnt, e_wcyc;
        logic [DW-1:0] rd, wdat, e_wdat;
        logic [AW-1:0] wnum;
        logic errs, oack, bexec, e_err;
        model_op(0, 2'b01, 3'd0, 3'd3, 16'd42, e_lat, e_wcnt, e_wcyc, e_wdat, e_err);
        do_op(0, 2'b01, 3'd0, 3'd3, 16'd42, lat, rd, wcnt, wcyc, wnum, wdat, errs, oack, bexec);
        checks++;
        if (lat != 2 || oack !== 1'b0) begin
            errors++; $display("FAIL write_latency got lat=%0d other_ack=%b want 2/0", lat, oack);
        end
        checks++;
        if (wcnt != 1 || wcyc != 1 || wnum !== 3'd3 || wdat !== 16'd42) begin
            errors++; $display("FAIL write_port got cnt=%0d cyc=%0d num=%0d data=%0d want 1/1/3/42", wcnt, wcyc, wnum, wdat);
        end
        checks++;
        if (bexec !== 1'b1) begin
            errors++; $display("FAIL busy_exec got %b want 1", bexec);
        end
        model_op(0, 2'b00, 3'd3, 3'd0, 16'd0, e_lat, e_wcnt, e_wcyc, e_wdat, e_err);
        do_op(0, 2'b00, 3'd3, 3'd0, 16'd0, lat, rd, wcnt, wcyc, wnum, wdat, errs, oack, bexec);
        checks++;
        if (lat != 2 || rd !== 16'd42 || wcnt != 0) begin
            errors++; $display("FAIL read_back got lat=%0d rdata=%0d writes=%0d want 2/42/0", lat, rd, wcnt);
        end
        // preload for contention: R1=69 via req1, R2=7 via req0
        model_op(1, 2'b01, 3'd0, 3'd1, 16'd69, e_lat, e_wcnt, e_wcyc, e_wdat, e_err);
        do_op(1, 2'b01, 3'd0, 3'd1, 16'd69, lat, rd, wcnt, wcyc, wnum, wdat, errs, oack, bexec);
        model_op(0, 2'b01, 3'd0, 3'd2, 16'd7, e_lat, e_wcnt, e_wcyc, e_wdat, e_err);
        do_op(0, 2'b01, 3'd0, 3'd2, 16'd7, lat, rd, wcnt, wcyc, wnum, wdat, errs, oack, bexec);
    endtask

    task automatic test_contention();
        int first, who, got;
        logic both_seen;
        first = -1; both_seen = 1'b0;
        set_req(0, 1'b1, 2'b00, 3'd1, 3'd0, 16'h0);
        set_req(1, 1'b1, 2'b00, 3'd2, 3'd0, 16'h0);
        for (int k = 0; k < 6; k++) begin
            got = 0;
            for (int n = 1; n <= 8; n++) begin
                @(posedge clk); #1;
                if (ack0 && ack1) both_seen = 1'b1;
                if (ack0 || ack1) begin got = 1; break; end
            end
            checks++;
            if (got == 0) begin
                errors++; $display("FAIL contention_timeout ack %0d never arrived", k);
                break;
            end
            who = ack1 ? 1 : 0;
            if (k == 0) first = who;
            checks++;
            if (who != (first ^ (k & 1))) begin
                errors++; $display("FAIL contention_order ack %0d got requester %0d want %0d", k, who, first ^ (k & 1));
            end
            checks++;
            if (((who == 0) ? rdata0 : rdata1) !== model_rf[(who == 0) ? 1 : 2]) begin
                errors++; $display("FAIL contention_rdata requester %0d got %0d want %0d", who,
                                   (who == 0) ? rdata0 : rdata1, model_rf[(who == 0) ? 1 : 2]);
            end
        end
        set_req(0, 1'b0, 2'b00, '0, '0, '0);
        set_req(1, 1'b0, 2'b00, '0, '0, '0);
        checks++;
        if (both_seen !== 1'b0) begin
            errors++; $display("FAIL contention_both_acks got both high want never");
        end
        model_rd[0] = model_rf[1]; model_rd[1] = model_rf[2];
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_copy();
        int lat, wcnt, wcyc, e_lat, e_wcnt, e_wcyc;
        logic [DW-1:0] rd, wdat, e_wdat;
        logic [AW-1:0] wnum;
        logic errs, oack, bexec, e_err;
        model_op(1, 2'b10, 3'd3, 3'd5, 16'h0, e_lat, e_wcnt, e_wcyc, e_wdat, e_err);
        do_op(1, 2'b10, 3'd3, 3'd5, 16'h0, lat, rd, wcnt, wcyc, wnum, wdat, errs, oack, bexec);
        checks++;
        if (lat != 3 || oack !== 1'b0) begin
            errors++; $display("FAIL copy_latency got lat=%0d other_ack=%b want 3/0", lat, oack);
        end
        checks++;
        if (wcnt != 1 || wcyc != 2 || wnum !== 3'd5 || wdat !== 16'd42) begin
            errors++; $display("FAIL copy_port got cnt=%0d cyc=%0d num=%0d data=%0d want 1/2/5/42", wcnt, wcyc, wnum, wdat);
        end
        model_op(0, 2'b00, 3'd5, 3'd0, 16'h0, e_lat, e_wcnt, e_wcyc, e_wdat, e_err);
        do_op(0, 2'b00, 3'd5, 3'd0, 16'h0, lat, rd, wcnt, wcyc, wnum, wdat, errs, oack, bexec);
        checks++;
        if (rd !== 16'd42) begin
            errors++; $display("FAIL copy_readback got %0d want 42", rd);
        end
    endtask

    task automatic test_reserved();
        int lat, wcnt, wcyc, e_lat, e_wcnt, e_wcyc;
        logic [DW-1:0] rd, wdat, e_wdat;
        logic [AW-1:0] wnum;
        logic errs, oack, bexec, e_err;
        model_op(1, 2'b11, 3'd4, 3'd6, 16'hDEAD, e_lat, e_wcnt, e_wcyc, e_wdat, e_err);
        do_op(1, 2'b11, 3'd4, 3'd6, 16'hDEAD, lat, rd, wcnt, wcyc, wnum, wdat, errs, oack, bexec);
        checks++;
        if (lat != 2 || wcnt != 0 || rd !== model_rd[1]) begin
            errors++; $display("FAIL reserved_op got lat=%0d writes=%0d rdata1=%h want 2/0/%h", lat, wcnt, rd, model_rd[1]);
        end
    endtask

    task automatic test_reset_abort();
        int lat, wcnt, wcyc, e_lat, e_wcnt, e_wcyc;
        logic [DW-1:0] rd, wdat, e_wdat;
        logic [AW-1:0] wnum;
        logic errs, oack, bexec, e_err, ack_in_reset;
        model_op(0, 2'b01, 3'd0, 3'd6, 16'd9, e_lat, e_wcnt, e_wcyc, e_wdat, e_err);
        do_op(0, 2'b01, 3'd0, 3'd6, 16'd9, lat, rd, wcnt, wcyc, wnum, wdat, errs, oack, bexec);
        set_req(0, 1'b1, 2'b01, 3'd0, 3'd6, 16'h1234);
        @(posedge clk); #1;
        checks++;
        if (rf_write !== 1'b1 || rf_writenum !== 3'd6) begin
            errors++; $display("FAIL abort_exec got rf_write=%b num=%0d want 1/6", rf_write, rf_writenum);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ack0, ack1, busy, rf_write} !== 4'b0000) begin
            errors++; $display("FAIL abort_async got ack0/ack1/busy/rf_write=%b want 0000", {ack0, ack1, busy, rf_write});
        end
        set_req(0, 1'b0, 2'b00, '0, '0, '0);
        ack_in_reset = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (ack0 || ack1) ack_in_reset = 1'b1;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (ack0 || ack1) ack_in_reset = 1'b1;
        end
        checks++;
        if (ack_in_reset !== 1'b0) begin
            errors++; $display("FAIL abort_no_ack got an ack want none");
        end
        model_rd[0] = '0; model_rd[1] = '0;
        model_op(0, 2'b00, 3'd6, 3'd0, 16'h0, e_lat, e_wcnt, e_wcyc, e_wdat, e_err);
        do_op(0, 2'b00, 3'd6, 3'd0, 16'h0, lat, rd, wcnt, wcyc, wnum, wdat, errs, oack, bexec);
        checks++;
        if (rd !== 16'd9 || lat != 2) begin
            errors++; $display("FAIL abort_readback got rdata=%0d lat=%0d want 9/2", rd, lat);
        end
    endtask

`ifdef RF_ARB_R0_PROTECT_EN
    task automatic test_r0_protect();
        int lat, wcnt, wcyc, e_lat, e_wcnt, e_wcyc;
        logic [DW-1:0] rd, wdat, e_wdat;
        logic [AW-1:0] wnum;
        logic errs, oack, bexec, e_err;
        model_op(0, 2'b01, 3'd0, 3'd0, 16'hBEEF, e_lat, e_wcnt, e_wcyc, e_wdat, e_err);
        do_op(0, 2'b01, 3'd0, 3'd0, 16'hBEEF, lat, rd, wcnt, wcyc, wnum, wdat, errs, oack, bexec);
        checks++;
        if (errs !== 1'b1 || wcnt != 0 || lat != 2) begin
            errors++; $display("FAIL r0_protect got err=%b writes=%0d lat=%0d want 1/0/2", errs, wcnt, lat);
        end
        model_op(1, 2'b00, 3'd0, 3'd0, 16'h0, e_lat, e_wcnt, e_wcyc, e_wdat, e_err);
        do_op(1, 2'b00, 3'd0, 3'd0, 16'h0, lat, rd, wcnt, wcyc, wnum, wdat, errs, oack, bexec);
        checks++;
        if (rd !== model_rd[1] || errs !== 1'b0) begin
            errors++; $display("FAIL r0_unchanged got R0=%h err=%b want %h/0", rd, errs, model_rd[1]);
        end
    endtask
`endif

    task automatic test_random();
        int who, lat, wcnt, wcyc, e_lat, e_wcnt, e_wcyc;
        logic [1:0] op;
        logic [AW-1:0] src, dst, wnum;
        logic [DW-1:0] wd, rd, wdat, e_wdat;
        logic errs, oack, bexec, e_err;
        for (int t = 0; t < 40; t++) begin
            who = int'($urandom_range(0, 1));
            op  = 2'($urandom_range(0, 3));
            src = AW'($urandom_range(0, 7));
            dst = AW'($urandom_range(0, 7));
            wd  = DW'($urandom);
            model_op(who, op, src, dst, wd, e_lat, e_wcnt, e_wcyc, e_wdat, e_err);
            do_op(who, op, src, dst, wd, lat, rd, wcnt, wcyc, wnum, wdat, errs, oack, bexec);
            checks++;
            if (lat != e_lat || oack !== 1'b0 || rd !== model_rd[who] || errs !== e_err) begin
                errors++; $display("FAIL rand_%0d_result req%0d op=%0d got lat=%0d rdata=%h err=%b oack=%b want %0d/%h/%b/0",
                                   t, who, op, lat, rd, errs, oack, e_lat, model_rd[who], e_err);
            end
            checks++;
            if (wcnt != e_wcnt || (e_wcnt == 1 && (wcyc != e_wcyc || wnum !== dst || wdat !== e_wdat))) begin
                errors++; $display("FAIL rand_%0d_write op=%0d got cnt=%0d cyc=%0d num=%0d data=%h want %0d/%0d/%0d/%h",
                                   t, op, wcnt, wcyc, wnum, wdat, e_wcnt, e_wcyc, dst, e_wdat);
            end
        end
    endtask

    initial begin
        rf_clear = 1'b0;
        set_req(0, 1'b0, 2'b00, '0, '0, '0);
        set_req(1, 1'b0, 2'b00, '0, '0, '0);
        test_reset();
        test_write_read();
        test_contention();
        test_copy();
        test_reserved();
        test_reset_abort();
`ifdef RF_ARB_R0_PROTECT_EN
        test_r0_protect();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
